// File: rtl/mvu_pkg.sv
// Shared MVU helpers: result-width calculation for adder trees plus the
// configuration record and register-placement rule of the streaming adder.
package mvu_pkg;

  // Elaboration-time configuration of one add_multi_stream instance.
  typedef struct packed {
    int     n;
    int     arg_width;
    longint arg_lo;
    longint arg_hi;
    int     depth;
    int     acc_width;
  } add_multi_stream_cfg_t;

  // Bits needed to hold the sum of n addends in [arg_lo, arg_hi].
  // arg_hi == 0 means the full arg_width range; arg_lo < 0 means signed.
  function automatic int sumwidth(int n, int arg_width, longint arg_lo, longint arg_hi);
    longint hi;
    longint smin;
    longint smax;
    int     w;
    if (arg_hi != 0)     hi = arg_hi;
    else if (arg_lo < 0) hi = (longint'(1) << (arg_width - 1)) - 1;
    else                 hi = (longint'(1) << arg_width) - 1;
    smax = longint'(n) * hi;
    smin = longint'(n) * arg_lo;
    w = 1;
    if (arg_lo < 0) begin
      while ((smin < -(longint'(1) << (w - 1))) || (smax > (longint'(1) << (w - 1)) - 1)) w++;
    end else begin
      while (smax > (longint'(1) << w) - 1) w++;
    end
    return w;
  endfunction

  // True when a register follows tree level `level` (1 = first adder level,
  // l_total = root). The d registers are spread as evenly as possible, with
  // the last one always directly behind the root.
  function automatic bit tree_reg_level(int level, int l_total, int d);
    if (l_total == 0 || level < 1 || level > l_total) return 1'b0;
    return ((level * d) / l_total) > (((level - 1) * d) / l_total);
  endfunction

endpackage

// File: rtl/add_multi_stream_if.sv
// Input beat stream and output result stream of add_multi_stream.
interface add_multi_stream_if #(
  parameter int N         = 8,
  parameter int ARG_WIDTH = 8,
  parameter int ACC_WIDTH = 32
);
  // Handshake: a beat/result moves when valid && ready are both high at a
  // rising clock edge. A valid producer holds its data stable until that
  // edge; ready may depend combinationally on the consumer side (irdy
  // follows ordy in the same cycle).
  logic [N-1:0][ARG_WIDTH-1:0] idat;
  logic                        ilast;
  logic                        ivld;
  logic                        irdy;
  logic [ACC_WIDTH-1:0]        odat;
  logic                        ovld;
  logic                        ordy;

  modport master (output idat, ilast, ivld, ordy, input irdy, odat, ovld);
  modport slave  (input idat, ilast, ivld, ordy, output irdy, odat, ovld);
endinterface

// File: rtl/add_tree_pipe.sv
// Enable-gated balanced adder tree with a matching valid/last sideband.
// Leaves are padded with zeros up to the next power of two; nodes live in a
// heap-ordered array (root at 1, children of k at 2k and 2k+1).
module add_tree_pipe
  import mvu_pkg::*;
#(
  parameter int N         = 8,
  parameter int ARG_WIDTH = 8,
  parameter int ARG_LO    = 0,
  parameter int ARG_HI    = 0,
  parameter int DEPTH     = 2,
  parameter int SW        = 11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [N-1:0][ARG_WIDTH-1:0] arg,
  input  logic                        vld_i,
  input  logic                        last_i,
  output logic [SW-1:0]               sum,
  output logic                        vld_o,
  output logic                        last_o
);
  localparam int L   = $clog2(N);
  localparam int NP  = 1 << L;
  localparam int D   = (DEPTH < 0) ? 0 : ((DEPTH < L) ? DEPTH : L);
  localparam bit SGN = (ARG_LO < 0);

  logic [SW-1:0] node [1:2*NP-1];

  for (genvar i = 0; i < NP; i++) begin : g_leaf
    if (i < N) begin : g_arg
      if (SGN) begin : g_s
        assign node[NP+i] = SW'($signed(arg[i]));
      end else begin : g_u
        assign node[NP+i] = SW'(arg[i]);
      end
    end else begin : g_pad
      assign node[NP+i] = '0;
    end
  end

  for (genvar l = 1; l <= L; l++) begin : g_lvl
    for (genvar i = 0; i < (1 << (L - l)); i++) begin : g_node
      localparam int K  = (1 << (L - l)) + i;
      localparam int NL = ((1 << l) < N) ? (1 << l) : N;
      localparam int LW = sumwidth(NL, ARG_WIDTH, ARG_LO, ARG_HI);
      logic [LW-1:0] s;
      logic [SW-1:0] s_ext;
      // Node adder runs at the width its leaf count needs.
      assign s = LW'(node[2*K]) + LW'(node[2*K+1]);
      if (SGN) begin : g_s
        assign s_ext = SW'($signed(s));
      end else begin : g_u
        assign s_ext = SW'(s);
      end
      if (tree_reg_level(l, L, D)) begin : g_reg
        logic [SW-1:0] q;
        // Pipeline register behind this level; frozen during a stall.
        always_ff @(posedge clk) begin
          if (en) q <= s_ext;
        end
        assign node[K] = q;
      end else begin : g_comb
        assign node[K] = s_ext;
      end
    end
  end

  assign sum = node[1];

  if (D == 0) begin : g_nosb
    assign vld_o  = vld_i;
    assign last_o = last_i;
  end else begin : g_sb
    logic [D-1:0] vld_sr;
    logic [D-1:0] last_sr;
    // Valid/last travel alongside the data through the same D registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_sr  <= '0;
        last_sr <= '0;
      end else if (en) begin
        vld_sr[0]  <= vld_i;
        last_sr[0] <= last_i;
        for (int j = 1; j < D; j++) begin
          vld_sr[j]  <= vld_sr[j-1];
          last_sr[j] <= last_sr[j-1];
        end
      end
    end
    assign vld_o  = vld_sr[D-1];
    assign last_o = last_sr[D-1];
  end

endmodule

// File: rtl/add_multi_stream.sv
// Streaming multi-lane adder: reduces N lanes per beat through a pipelined
// tree, then accumulates beats into one result per packet (ilast ends it).
// A single global enable stalls the whole pipeline while a result waits.
module add_multi_stream
  import mvu_pkg::*;
#(
  parameter int N         = 8,
  parameter int ARG_WIDTH = 8,
  parameter int ARG_LO    = 0,
  parameter int ARG_HI    = 0,
  parameter int DEPTH     = 2,
  parameter int ACC_WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  add_multi_stream_if.slave bus
);
  localparam int SW  = sumwidth(N, ARG_WIDTH, ARG_LO, ARG_HI);
  localparam bit SGN = (ARG_LO < 0);

  logic                 en;
  logic                 accept;
  logic [SW-1:0]        tree_sum;
  logic                 t_vld;
  logic                 t_last;
  logic [ACC_WIDTH-1:0] ext_sum;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] odat_q;
  logic                 first_q;
  logic                 ovld_q;

  // Everything advances unless a finished result is blocked downstream.
  assign en       = !(ovld_q && !bus.ordy);
  assign bus.irdy = en && !rst;
  assign accept   = bus.ivld && bus.irdy;

  add_tree_pipe #(
    .N         (N),
    .ARG_WIDTH (ARG_WIDTH),
    .ARG_LO    (ARG_LO),
    .ARG_HI    (ARG_HI),
    .DEPTH     (DEPTH),
    .SW        (SW)
  ) u_tree (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .arg    (bus.idat),
    .vld_i  (accept),
    .last_i (bus.ilast),
    .sum    (tree_sum),
    .vld_o  (t_vld),
    .last_o (t_last)
  );

  if (SGN) begin : g_ext_s
    assign ext_sum = ACC_WIDTH'($signed(tree_sum));
  end else begin : g_ext_u
    assign ext_sum = ACC_WIDTH'(tree_sum);
  end

  // Wraps modulo 2^ACC_WIDTH; the first beat of a packet ignores acc_q.
  assign acc_next = (first_q ? '0 : acc_q) + ext_sum;

  // Accumulator, packet-start flag and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      first_q <= 1'b1;
      odat_q  <= '0;
      ovld_q  <= 1'b0;
    end else begin
      if (ovld_q && bus.ordy) ovld_q <= 1'b0;
      if (en && t_vld) begin
        if (t_last) begin
          odat_q  <= acc_next;
          ovld_q  <= 1'b1;
          acc_q   <= '0;
          first_q <= 1'b1;
        end else begin
          acc_q   <= acc_next;
          first_q <= 1'b0;
        end
      end
    end
  end

  assign bus.odat = odat_q;
  assign bus.ovld = ovld_q;

endmodule

// File: tb/tb_add_multi_stream.sv
// Bench for add_multi_stream: three configurations (unsigned N=8 D=2,
// signed N=8 with clamped depth, narrow-accumulator N=2).
module tb_add_multi_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] acc_m = '0;
  logic        rst_d = 1'b0;
  logic        hold_d = 1'b0;
  logic [31:0] odat_d = '0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  add_multi_stream_if #(.N(8), .ARG_WIDTH(8), .ACC_WIDTH(32)) ua_if ();
  add_multi_stream_if #(.N(8), .ARG_WIDTH(8), .ACC_WIDTH(32)) sa_if ();
  add_multi_stream_if #(.N(2), .ARG_WIDTH(8), .ACC_WIDTH(10)) wa_if ();

  add_multi_stream #(.N(8), .ARG_WIDTH(8), .ARG_LO(0), .ARG_HI(0), .DEPTH(2), .ACC_WIDTH(32))
    u_ua (.clk(clk), .rst(rst), .bus(ua_if.slave));
  add_multi_stream #(.N(8), .ARG_WIDTH(8), .ARG_LO(-128), .ARG_HI(0), .DEPTH(5), .ACC_WIDTH(32))
    u_sa (.clk(clk), .rst(rst), .bus(sa_if.slave));
  add_multi_stream #(.N(2), .ARG_WIDTH(8), .ARG_LO(0), .ARG_HI(0), .DEPTH(1), .ACC_WIDTH(10))
    u_wa (.clk(clk), .rst(rst), .bus(wa_if.slave));

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard on the unsigned instance: model sums pushed on accept,
  // popped on output handshake; also reset, hold and throughput rules.
  always @(negedge clk) begin
    if (rst) begin
      if (rst_d) begin
        check("rst_ovld", 64'(ua_if.ovld), 64'd0);
        check("rst_odat", 64'(ua_if.odat), 64'd0);
      end
      check("rst_irdy", 64'(ua_if.irdy), 64'd0);
      acc_m  = '0;
      exp_q.delete();
      hold_d = 1'b0;
    end else begin
      if (rst_d) check("irdy_after_rst", 64'(ua_if.irdy), 64'd1);
      if (hold_d) begin
        check("hold_ovld", 64'(ua_if.ovld), 64'd1);
        check("hold_odat", 64'(ua_if.odat), 64'(odat_d));
      end
      if (ua_if.ivld && ua_if.ordy) check("thru_irdy", 64'(ua_if.irdy), 64'd1);
      if (ua_if.ivld && ua_if.irdy) begin
        for (int i = 0; i < 8; i++) acc_m = acc_m + 32'(ua_if.idat[i]);
        if (ua_if.ilast) begin
          exp_q.push_back(acc_m);
          acc_m = '0;
        end
      end
      if (ua_if.ovld && ua_if.ordy) begin
        if (exp_q.size() == 0) check("sb_extra", 64'(ua_if.ovld), 64'd0);
        else check("sb_odat", 64'(ua_if.odat), 64'(exp_q.pop_front()));
      end
      hold_d = ua_if.ovld && !ua_if.ordy;
      odat_d = ua_if.odat;
    end
    rst_d = rst;
  end

  // ---------------- driver tasks ----------------
  task automatic ua_send(input logic [63:0] lanes, input logic last, output int acc_cyc);
    bit ok = 1'b0;
    acc_cyc = 0;
    ua_if.idat  = lanes;
    ua_if.ilast = last;
    ua_if.ivld  = 1'b1;
    for (int g = 0; g < 1000 && !ok; g++) begin
      @(negedge clk);
      ok = ua_if.irdy && !rst;
      acc_cyc = cyc;
      @(posedge clk); #1;
    end
    ua_if.ivld = 1'b0;
    if (!ok) check("send_timeout", 64'(ua_if.irdy), 64'd1);
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 300 && (exp_q.size() != 0 || ua_if.ovld); k++) @(negedge clk);
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [63:0] lanes;
    int          t0;
    int          beats;
    int          len;
    bit          done;
    bit          seen;

    ua_if.idat = '0; ua_if.ilast = 1'b0; ua_if.ivld = 1'b0; ua_if.ordy = 1'b1;
    sa_if.idat = '0; sa_if.ilast = 1'b0; sa_if.ivld = 1'b0; sa_if.ordy = 1'b1;
    wa_if.idat = '0; wa_if.ilast = 1'b0; wa_if.ivld = 1'b0; wa_if.ordy = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_s_ovld", 64'(sa_if.ovld), 64'd0);
    check("rst_w_odat", 64'(wa_if.odat), 64'd0);
    check("rst_w_irdy", 64'(wa_if.irdy), 64'd1);

    // Lanes 1..8 in one last beat: 36 three cycles after acceptance.
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) lanes[8*i +: 8] = 8'(i + 1);
    ua_send(lanes, 1'b1, t0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = ua_if.ovld;
    end
    check("t1_ovld", 64'(ua_if.ovld), 64'd1);
    check("t1_lat", 64'(cyc - t0), 64'd3);
    check("t1_odat", 64'(ua_if.odat), 64'd36);
    wait_drain("t1_drain");

    // Signed: -128 x8, 127 x8, -1 x8 -> -16; depth clamps to 3, latency 4.
    @(posedge clk); #1;
    sa_if.idat = {8{8'h80}}; sa_if.ilast = 1'b0; sa_if.ivld = 1'b1;
    @(posedge clk); #1;
    sa_if.idat = {8{8'h7f}};
    @(posedge clk); #1;
    sa_if.idat = {8{8'hff}}; sa_if.ilast = 1'b1;
    @(negedge clk);
    t0 = cyc;
    check("t2_irdy", 64'(sa_if.irdy), 64'd1);
    @(posedge clk); #1;
    sa_if.ivld = 1'b0; sa_if.ilast = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = sa_if.ovld;
    end
    check("t2_ovld", 64'(sa_if.ovld), 64'd1);
    check("t2_lat", 64'(cyc - t0), 64'd4);
    check("t2_odat", 64'(sa_if.odat), 64'(32'hffff_fff0));
    @(negedge clk);
    check("t2_ovld_clr", 64'(sa_if.ovld), 64'd0);

    // Wrap: N=2, ACC_WIDTH=10, 4 beats of 255+255 -> 2040 mod 1024 = 1016.
    @(posedge clk); #1;
    wa_if.idat = 16'hffff; wa_if.ilast = 1'b0; wa_if.ivld = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    wa_if.ilast = 1'b1;
    @(negedge clk);
    t0 = cyc;
    @(posedge clk); #1;
    wa_if.ivld = 1'b0; wa_if.ilast = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = wa_if.ovld;
    end
    check("t4_ovld", 64'(wa_if.ovld), 64'd1);
    check("t4_lat", 64'(cyc - t0), 64'd2);
    check("t4_odat", 64'(wa_if.odat), 64'd1016);

    // Backpressure: ordy low for 10 cycles while 1-beat packets stream.
    @(posedge clk); #1;
    ua_if.ordy = 1'b0;
    fork
      begin
        int tx;
        for (int p = 0; p < 6; p++) ua_send({8{8'(p + 3)}}, 1'b1, tx);
      end
      begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (ua_if.ovld) check("t3_irdy_low", 64'(ua_if.irdy), 64'd0);
        end
        check("t3_ovld_held", 64'(ua_if.ovld), 64'd1);
        @(posedge clk); #1;
        ua_if.ordy = 1'b1;
      end
    join
    wait_drain("t3_drain");

    // Reset mid-packet: partial sum from the two beats must vanish.
    @(posedge clk); #1;
    ua_send({8{8'd5}}, 1'b0, t0);
    ua_send({8{8'd7}}, 1'b0, t0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ua_send({8{8'd1}}, 1'b1, t0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = ua_if.ovld;
    end
    check("t5_ovld", 64'(ua_if.ovld), 64'd1);
    check("t5_odat", 64'(ua_if.odat), 64'd8);
    wait_drain("t5_drain");

    // Random packets (1..16 beats), random bubbles and random ordy.
    done = 1'b0;
    fork
      begin
        beats = 0;
        while (beats < 10000) begin
          len = $urandom_range(1, 16);
          for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 3) == 0) begin
              @(posedge clk); #1;
            end
            for (int i = 0; i < 8; i++) lanes[8*i +: 8] = 8'($urandom_range(0, 255));
            ua_send(lanes, (b == len - 1), t0);
            beats++;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          ua_if.ordy = ($urandom_range(0, 3) != 0);
        end
      end
    join
    ua_if.ordy = 1'b1;
    wait_drain("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
